lsu_queue: RTL

LSU_QUEUE -- requirements
Module: lsu_queue

---
 rtl/lsu_queue.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_queue.sv
// lsu_queue: in-order load/store request queue with a single-outstanding bus engine.
//
// Requests are accepted into a DEPTH-entry FIFO and executed one at a time.
// Byte accesses use one beat on the lane selected by the low address bits.
// Word accesses that are not lane-aligned are split into two beats, and the
// data is rotated to match. Read lanes are merged back into a right-aligned
// result and returned with the request tag on a one-cycle writeback pulse.
//
// Ports
//   clk, a_rst          clock, asynchronous active-low reset
//   rq_*                request offer (start/addr/data/width/cmd/tag), rq_ack accept
//   full, empty         queue status
//   mem_rdy             beat completes this cycle; mem_data_in valid with it
//   mem_addr/data/be    beat address (lane-aligned), lane-positioned data, lane enables
//   mem_cmd             1 = write
//   mem_bus_assert      a beat is in progress
//   wb_valid/data/tag   read writeback

module lsu_queue #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 1
) (
    input  logic              clk,
    input  logic              a_rst,
    input  logic              rq_start,
    input  logic [AW-1:0]     rq_addr,
    input  logic [DW-1:0]     rq_data,
    input  logic              rq_width,
    input  logic              rq_cmd,
    input  logic [TW-1:0]     rq_tag,
    output logic              rq_ack,
    output logic              full,
    output logic              empty,
    input  logic              mem_rdy,
    input  logic [DW-1:0]     mem_data_in,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_data,
    output logic              mem_cmd,
    output logic [DW/8-1:0]   mem_be,
    output logic              mem_bus_assert,
    output logic              wb_valid,
    output logic [DW-1:0]     wb_data,
    output logic [TW-1:0]     wb_tag
);

    localparam int unsigned BE = DW / 8;
    localparam int unsigned OW = $clog2(BE);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [BE-1:0] BE_ALL = {BE{1'b1}};
    localparam logic [BE-1:0] BE_ONE = {{(BE-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StWb} state_e;

    // Lane j receives source lane (j - n) mod BE.
    function automatic logic [DW-1:0] rot_up(input logic [DW-1:0] d, input logic [OW-1:0] n);
        logic [DW-1:0] r;
        logic [OW-1:0] src;
        r = '0;
        for (int j = 0; j < int'(BE); j++) begin
            src = OW'(j) - n;
            r[j*8 +: 8] = d[int'(src)*8 +: 8];
        end
        return r;
    endfunction

    // Lane j receives source lane (j + n) mod BE.
    function automatic logic [DW-1:0] rot_dn(input logic [DW-1:0] d, input logic [OW-1:0] n);
        logic [DW-1:0] r;
        logic [OW-1:0] src;
        r = '0;
        for (int j = 0; j < int'(BE); j++) begin
            src = OW'(j) + n;
            r[j*8 +: 8] = d[int'(src)*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_mask(input logic [BE-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int j = 0; j < int'(BE); j++) begin
            m[j*8 +: 8] = {8{be[j]}};
        end
        return m;
    endfunction

    // Queue storage
    logic [AW-1:0] q_addr_q  [DEPTH];
    logic [DW-1:0] q_data_q  [DEPTH];
    logic          q_width_q [DEPTH];
    logic          q_cmd_q   [DEPTH];
    logic [TW-1:0] q_tag_q   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    state_e        state_q, state_d;
    logic          cur_split_q, cur_split_d;
    logic          cur_cmd_q, cur_cmd_d;
    logic          cur_width_q, cur_width_d;
    logic [OW-1:0] cur_off_q, cur_off_d;
    logic [TW-1:0] cur_tag_q, cur_tag_d;
    logic [DW-1:0] rd_buf_q, rd_buf_d;

    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic [BE-1:0] mem_be_q, mem_be_d;
    logic          mem_cmd_q, mem_cmd_d;
    logic          bus_q, bus_d;
    logic          wb_valid_q, wb_valid_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [TW-1:0] wb_tag_q, wb_tag_d;

    logic          idle, enq, deq, start_rq, beat_done;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data;
    logic          src_width, src_cmd;
    logic [TW-1:0] src_tag;
    logic [OW-1:0] src_off;
    logic [AW-1:0] src_base;
    logic [BE-1:0] src_be;
    logic [DW-1:0] src_wdata;
    logic [DW-1:0] merged, rd_res, be_mask;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    // Gated by reset so no accept is signalled while the block is held in reset.
    assign rq_ack = rq_start & ~full & a_rst;

    assign idle     = (state_q == StIdle);
    assign deq      = idle & ~empty;
    // With an idle engine and an empty queue the offer goes straight to the bus.
    assign enq      = rq_ack & ~(idle & empty);
    assign start_rq = idle & (~empty | rq_ack);

    // Head of queue, or the incoming request when bypassing.
    always_comb begin
        if (empty) begin
            src_addr  = rq_addr;
            src_data  = rq_data;
            src_width = rq_width;
            src_cmd   = rq_cmd;
            src_tag   = rq_tag;
        end else begin
            src_addr  = q_addr_q[rd_ptr_q];
            src_data  = q_data_q[rd_ptr_q];
            src_width = q_width_q[rd_ptr_q];
            src_cmd   = q_cmd_q[rd_ptr_q];
            src_tag   = q_tag_q[rd_ptr_q];
        end
        src_off  = src_addr[OW-1:0];
        src_base = {src_addr[AW-1:OW], {OW{1'b0}}};
        if (src_width) begin
            src_be    = BE_ALL << src_off;
            src_wdata = rot_up(src_data, src_off);
        end else begin
            src_be    = BE_ONE << src_off;
            src_wdata = rot_up({{(DW-8){1'b0}}, src_data[7:0]}, src_off);
        end
    end

    // Read lane merge and realignment to the request address.
    always_comb begin
        be_mask = lane_mask(mem_be_q);
        merged  = (rd_buf_q & ~be_mask) | (mem_data_in & be_mask);
        rd_res  = rot_dn(merged, cur_off_q);
        if (!cur_width_q) begin
            rd_res = {{(DW-8){1'b0}}, rd_res[7:0]};
        end
    end

    assign beat_done = mem_rdy & ((state_q == StBeat1) | ((state_q == StBeat0) & ~cur_split_q));

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(enq);
        rd_ptr_d = rd_ptr_q + PW'(deq);
        count_d  = count_q + CW'(enq) - CW'(deq);
    end

    always_comb begin
        state_d     = state_q;
        cur_split_d = cur_split_q;
        cur_cmd_d   = cur_cmd_q;
        cur_width_d = cur_width_q;
        cur_off_d   = cur_off_q;
        cur_tag_d   = cur_tag_q;
        rd_buf_d    = rd_buf_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_be_d    = mem_be_q;
        mem_cmd_d   = mem_cmd_q;
        bus_d       = bus_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_tag_d    = wb_tag_q;

        unique case (state_q)
            StIdle: begin
                if (start_rq) begin
                    state_d     = StBeat0;
                    cur_split_d = src_width & (src_off != '0);
                    cur_cmd_d   = src_cmd;
                    cur_width_d = src_width;
                    cur_off_d   = src_off;
                    cur_tag_d   = src_tag;
                    rd_buf_d    = '0;
                    mem_addr_d  = src_base;
                    mem_data_d  = src_wdata;
                    mem_be_d    = src_be;
                    mem_cmd_d   = src_cmd;
                    bus_d       = 1'b1;
                end
            end
            StBeat0: begin
                if (mem_rdy) begin
                    rd_buf_d = merged;
                    if (cur_split_q) begin
                        // Second beat: next aligned word, remaining low lanes.
                        state_d    = StBeat1;
                        mem_addr_d = mem_addr_q + AW'(BE);
                        mem_be_d   = ~mem_be_q;
                    end
                end
            end
            StBeat1: begin
                if (mem_rdy) begin
                    rd_buf_d = merged;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (beat_done) begin
            bus_d = 1'b0;
            if (cur_cmd_q) begin
                state_d = StIdle;
            end else begin
                state_d    = StWb;
                wb_valid_d = 1'b1;
                wb_data_d  = rd_res;
                wb_tag_d   = cur_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_split_q <= 1'b0;
            cur_cmd_q   <= 1'b0;
            cur_width_q <= 1'b0;
            cur_off_q   <= '0;
            cur_tag_q   <= '0;
            rd_buf_q    <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_be_q    <= '0;
            mem_cmd_q   <= 1'b0;
            bus_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_tag_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_split_q <= cur_split_d;
            cur_cmd_q   <= cur_cmd_d;
            cur_width_q <= cur_width_d;
            cur_off_q   <= cur_off_d;
            cur_tag_q   <= cur_tag_d;
            rd_buf_q    <= rd_buf_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_be_q    <= mem_be_d;
            mem_cmd_q   <= mem_cmd_d;
            bus_q       <= bus_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_tag_q    <= wb_tag_d;
        end
    end

    // Entry payload needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr_q[wr_ptr_q]  <= rq_addr;
            q_data_q[wr_ptr_q]  <= rq_data;
            q_width_q[wr_ptr_q] <= rq_width;
            q_cmd_q[wr_ptr_q]   <= rq_cmd;
            q_tag_q[wr_ptr_q]   <= rq_tag;
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_data       = mem_data_q;
    assign mem_be         = mem_be_q;
    assign mem_cmd        = mem_cmd_q;
    assign mem_bus_assert = bus_q;
    assign wb_valid       = wb_valid_q;
    assign wb_data        = wb_data_q;
    assign wb_tag         = wb_tag_q;

endmodule
